// File: rtl/avalon_ram_slave.sv
// Avalon-MM slave around a single-port word RAM with byte-lane writes.
// Every accepted transfer stalls for a fixed number of wait states.
module avalon_ram_slave #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic [3:0]  avs_byteenable,
   output logic [31:0] avs_readdata,
   output logic        avs_waitrequest
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(WAIT_STATES + 1);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t          state, stateNext;
   logic [CW-1:0]   cnt, cntNext;
   logic [31:0]     mem [DEPTH_WORDS];
   logic [AW-1:0]   wordIdx;
   logic            req;
   logic            unusedAddrBits;

   assign wordIdx        = avs_address[AW+1:2];
   assign unusedAddrBits = ^{avs_address[31:AW+2], avs_address[1:0]};
   assign req            = avs_read | avs_write;

   // Stall is combinational so a new request is held off in the very cycle it appears.
   assign avs_waitrequest = req && (state != ACK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      case (state)
         IDLE: begin
            if (req) begin
               cntNext   = CW'(1);
               stateNext = (WAIT_STATES == 1) ? ACK : WAIT;
            end
         end
         WAIT: begin
            // A dropped request is a master protocol violation; abandon it silently.
            if (!req) begin
               stateNext = IDLE;
            end else begin
               cntNext = cnt + CW'(1);
               if (cnt == CW'(WAIT_STATES - 1)) stateNext = ACK;
            end
         end
         ACK:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Read data is captured on the edge into ACK and then held until the next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         avs_readdata <= '0;
      end else if (stateNext == ACK && avs_read && !avs_write) begin
         avs_readdata <= mem[wordIdx];
      end
   end

   always_ff @(posedge clk) begin
      if (state == ACK && avs_write) begin
         for (int n = 0; n < 4; n++) begin
            if (avs_byteenable[n]) mem[wordIdx][8*n +: 8] <= avs_writedata[8*n +: 8];
         end
      end
   end

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Bench for avalon_ram_slave: two instances (1 wait state / 1024 words and
// 3 wait states / 16 words) checked against a word-array reference model.
module tb_avalon_ram_slave;

   logic        clk;
   logic        rst_n;
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [3:0]  be    [2];
   logic        rd    [2];
   logic        wr    [2];
   logic [31:0] rdata [2];
   logic        wreq  [2];

   int checks   = 0;
   int failures = 0;

   int          wsOf    [2] = '{1, 3};
   int          depthOf [2] = '{1024, 16};
   logic [31:0] mdl     [2][1024];
   bit          known   [2][1024];
   logic [31:0] lastRd  [2];

   avalon_ram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .avs_address(addr[0]), .avs_read(rd[0]),
      .avs_write(wr[0]), .avs_writedata(wdata[0]), .avs_byteenable(be[0]),
      .avs_readdata(rdata[0]), .avs_waitrequest(wreq[0]));

   avalon_ram_slave #(.DEPTH_WORDS(16), .WAIT_STATES(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .avs_address(addr[1]), .avs_read(rd[1]),
      .avs_write(wr[1]), .avs_writedata(wdata[1]), .avs_byteenable(be[1]),
      .avs_readdata(rdata[1]), .avs_waitrequest(wreq[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a plain word array indexed modulo depth.
   function automatic int widx(input int d, input logic [31:0] a);
      return int'(a >> 2) % depthOf[d];
   endfunction

   function automatic logic [31:0] model_apply(input int d, input bit r, input bit w,
                                               input logic [31:0] a, input logic [31:0] wd,
                                               input logic [3:0] b);
      int i;
      i = widx(d, a);
      if (w) begin
         for (int n = 0; n < 4; n++)
            if (b[n]) mdl[d][i][8*n +: 8] = wd[8*n +: 8];
         if (b == 4'hF) known[d][i] = 1'b1;
      end else if (r) begin
         lastRd[d] = mdl[d][i];
      end
      return lastRd[d];
   endfunction

   // Called at a falling edge; returns at a falling edge with the request removed.
   task automatic xfer(input int d, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b,
                       output int stall, output logic [31:0] rdo);
      addr[d] = a; wdata[d] = wd; be[d] = b; rd[d] = r; wr[d] = w;
      stall = 0;
      #1;
      while (wreq[d] === 1'b1 && stall < 40) begin
         stall++;
         @(negedge clk);
         #1;
      end
      if (stall >= 40) stall = -1;
      rdo = rdata[d];
      @(negedge clk);
      rd[d] = 1'b0; wr[d] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         addr[d] = '0; wdata[d] = '0; be[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0;
         lastRd[d] = '0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rdata[d] !== 32'h0) begin
            failures++; $display("FAIL reset_rdata dut%0d got=%h exp=0", d, rdata[d]);
         end
         checks++;
         if (wreq[d] !== 1'b0) begin
            failures++; $display("FAIL reset_waitreq dut%0d got=%b exp=0", d, wreq[d]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int stall; logic [31:0] rdo, exp;
      exp = model_apply(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
      xfer(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, stall, rdo);
      checks++;
      if (stall !== 1) begin failures++; $display("FAIL basic_wr_stall got=%0d exp=1", stall); end
      exp = model_apply(0, 1, 0, 32'h10, 32'h0, 4'h0);
      xfer(0, 1, 0, 32'h10, 32'h0, 4'h0, stall, rdo);
      checks++;
      if (stall !== 1) begin failures++; $display("FAIL basic_rd_stall got=%0d exp=1", stall); end
      checks++;
      if (rdo !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rd_data got=%h exp=deadbeef", rdo); end
      #1;
      checks++;
      if (wreq[0] !== 1'b0) begin failures++; $display("FAIL basic_idle_waitreq got=%b exp=0", wreq[0]); end
      checks++;
      if (rdata[0] !== exp) begin failures++; $display("FAIL basic_rdata_hold got=%h exp=%h", rdata[0], exp); end
      @(negedge clk);
   endtask

   task automatic test_byte_lanes();
      int stall; logic [31:0] rdo, exp;
      exp = model_apply(0, 0, 1, 32'h20, 32'h11223344, 4'hF);
      xfer(0, 0, 1, 32'h20, 32'h11223344, 4'hF, stall, rdo);
      exp = model_apply(0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101);
      xfer(0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, stall, rdo);
      exp = model_apply(0, 1, 0, 32'h20, 32'h0, 4'h0);
      xfer(0, 1, 0, 32'h20, 32'h0, 4'h0, stall, rdo);
      checks++;
      if (rdo !== 32'h11BB33DD) begin failures++; $display("FAIL byte_lanes got=%h exp=11bb33dd", rdo); end
      exp = model_apply(0, 0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000);
      xfer(0, 0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, stall, rdo);
      checks++;
      if (stall !== 1) begin failures++; $display("FAIL be0_stall got=%0d exp=1", stall); end
      exp = model_apply(0, 1, 0, 32'h20, 32'h0, 4'h0);
      xfer(0, 1, 0, 32'h20, 32'h0, 4'h0, stall, rdo);
      checks++;
      if (rdo !== 32'h11BB33DD) begin failures++; $display("FAIL be0_nochange got=%h exp=11bb33dd", rdo); end
   endtask

   task automatic test_wait_states();
      int stall; logic [31:0] rdo, exp;
      exp = model_apply(1, 0, 1, 32'h4, 32'h0BADF00D, 4'hF);
      xfer(1, 0, 1, 32'h4, 32'h0BADF00D, 4'hF, stall, rdo);
      checks++;
      if (stall !== 3) begin failures++; $display("FAIL ws3_wr_stall got=%0d exp=3", stall); end
      exp = model_apply(1, 1, 0, 32'h4, 32'h0, 4'h0);
      xfer(1, 1, 0, 32'h4, 32'h0, 4'h0, stall, rdo);
      checks++;
      if (stall !== 3) begin failures++; $display("FAIL ws3_rd_stall got=%0d exp=3", stall); end
      checks++;
      if (rdo !== 32'h0BADF00D) begin failures++; $display("FAIL ws3_rd_data got=%h exp=0badf00d", rdo); end
      // Request abandoned after one stalled cycle.
      addr[1] = 32'h4; rd[1] = 1'b1; wr[1] = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (wreq[1] !== 1'b1) begin failures++; $display("FAIL drop_stall_high got=%b exp=1", wreq[1]); end
      rd[1] = 1'b0;
      #1;
      checks++;
      if (wreq[1] !== 1'b0) begin failures++; $display("FAIL drop_waitreq_low got=%b exp=0", wreq[1]); end
      @(negedge clk);
      exp = model_apply(1, 1, 0, 32'h4, 32'h0, 4'h0);
      xfer(1, 1, 0, 32'h4, 32'h0, 4'h0, stall, rdo);
      checks++;
      if (stall !== 3) begin failures++; $display("FAIL drop_restall got=%0d exp=3", stall); end
      checks++;
      if (rdo !== exp) begin failures++; $display("FAIL drop_rd_data got=%h exp=%h", rdo, exp); end
   endtask

   task automatic test_wrap();
      int stall; logic [31:0] rdo, exp;
      exp = model_apply(1, 0, 1, 32'h40, 32'h5, 4'hF);
      xfer(1, 0, 1, 32'h40, 32'h5, 4'hF, stall, rdo);
      exp = model_apply(1, 1, 0, 32'h0, 32'h0, 4'h0);
      xfer(1, 1, 0, 32'h0, 32'h0, 4'h0, stall, rdo);
      checks++;
      if (rdo !== 32'h5) begin failures++; $display("FAIL wrap16 got=%h exp=5", rdo); end
      exp = model_apply(0, 1, 0, 32'h1010, 32'h0, 4'h0);
      xfer(0, 1, 0, 32'h1010, 32'h0, 4'h0, stall, rdo);
      checks++;
      if (rdo !== 32'hDEADBEEF) begin failures++; $display("FAIL wrap1024 got=%h exp=deadbeef", rdo); end
   endtask

   task automatic test_both_high();
      int stall; logic [31:0] rdo, exp, prior;
      prior = lastRd[0];
      exp = model_apply(0, 1, 1, 32'h30, 32'h12345678, 4'hF);
      xfer(0, 1, 1, 32'h30, 32'h12345678, 4'hF, stall, rdo);
      checks++;
      if (rdo !== prior) begin failures++; $display("FAIL both_rdata_hold got=%h exp=%h", rdo, prior); end
      exp = model_apply(0, 1, 0, 32'h30, 32'h0, 4'h0);
      xfer(0, 1, 0, 32'h30, 32'h0, 4'h0, stall, rdo);
      checks++;
      if (rdo !== 32'h12345678) begin failures++; $display("FAIL both_written got=%h exp=12345678", rdo); end
   endtask

   task automatic test_reset_mid_wait();
      int stall; logic [31:0] rdo, exp;
      exp = model_apply(1, 0, 1, 32'h8, 32'hCAFEF00D, 4'hF);
      xfer(1, 0, 1, 32'h8, 32'hCAFEF00D, 4'hF, stall, rdo);
      exp = model_apply(1, 1, 0, 32'h8, 32'h0, 4'h0);
      xfer(1, 1, 0, 32'h8, 32'h0, 4'h0, stall, rdo);
      addr[1] = 32'h8; wdata[1] = 32'h99999999; be[1] = 4'hF; wr[1] = 1'b1;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rdata[d] !== 32'h0) begin
            failures++; $display("FAIL midwait_reset_rdata dut%0d got=%h exp=0", d, rdata[d]);
         end
         lastRd[d] = '0;
      end
      wr[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp = model_apply(1, 1, 0, 32'h8, 32'h0, 4'h0);
      xfer(1, 1, 0, 32'h8, 32'h0, 4'h0, stall, rdo);
      checks++;
      if (stall !== 3) begin failures++; $display("FAIL post_reset_stall got=%0d exp=3", stall); end
      checks++;
      if (rdo !== 32'hCAFEF00D) begin failures++; $display("FAIL midwait_retain got=%h exp=cafef00d", rdo); end
   endtask

   task automatic test_back_to_back();
      int stall; logic [31:0] rdo, exp, a, wd;
      logic [3:0] b;
      bit r, w;
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 40; k++) begin
            a  = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            wd = $urandom;
            b  = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
               0:       begin r = 1; w = 0; end
               1:       begin r = 0; w = 1; end
               default: begin r = 1; w = 1; end
            endcase
            if (!known[d][widx(d, a)]) begin r = 0; w = 1; b = 4'hF; end
            exp = model_apply(d, r, w, a, wd, b);
            xfer(d, r, w, a, wd, b, stall, rdo);
            checks++;
            if (stall !== wsOf[d]) begin
               failures++; $display("FAIL rand_stall dut%0d k=%0d got=%0d exp=%0d", d, k, stall, wsOf[d]);
            end
            checks++;
            if (rdo !== exp) begin
               failures++; $display("FAIL rand_rdata dut%0d k=%0d a=%h got=%h exp=%h", d, k, a, rdo, exp);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_byte_lanes();
      test_wait_states();
      test_wrap();
      test_both_high();
      test_reset_mid_wait();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
